// File: rtl/cam_pkg.sv
// Shared types and constants for the OV7670 capture path and the display side.
package cam_pkg;

    typedef enum logic [1:0] {
        StWaitVs,
        StSync,
        StSkip,
        StCapture
    } cap_state_t;

    // RGB444 pixel layout {R[3:0],G[3:0],B[3:0]}
    localparam int unsigned ChanW  = 4;
    localparam int unsigned PixW   = 3 * ChanW;
    localparam int unsigned RedLsb = 8;
    localparam int unsigned GrnLsb = 4;
    localparam int unsigned BluLsb = 0;

    function automatic int unsigned addr_width(input int unsigned w, input int unsigned h);
        return (w * h > 1) ? $clog2(w * h) : 1;
    endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// Frame-buffer write port driven by the camera capture stage.
interface ov7670_capture_if #(
    parameter int unsigned AddrW = 19
);
    logic [AddrW-1:0] w_addr;
    logic [11:0]      w_data;
    logic             w_en;

    modport master (output w_addr, output w_data, output w_en);
    modport slave  (input  w_addr, input  w_data, input  w_en);
endinterface

// File: rtl/rgb444_pair.sv
// Pairs consecutive bus bytes into one pixel: low nibble of the first byte, all of the second.
module rgb444_pair
    import cam_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            href_i,
    input  logic [7:0]      data_i,
    output logic            pix_valid_o,
    output logic [PixW-1:0] pix_o
);

    logic             phase_q, phase_d;
    logic [ChanW-1:0] r_q, r_d;

    // Dropping href clears the phase, so a trailing odd byte never carries into the next line.
    always_comb begin
        phase_d = href_i ? ~phase_q : 1'b0;
        r_d     = (href_i && !phase_q) ? data_i[ChanW-1:0] : r_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= 1'b0;
            r_q     <= '0;
        end else begin
            phase_q <= phase_d;
            r_q     <= r_d;
        end
    end

    assign pix_valid_o = href_i & phase_q;
    assign pix_o       = {r_q, data_i};

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture: frame sync FSM, start-up frame skipping, clipping and linear buffer writes.
module ov7670_capture
    import cam_pkg::*;
#(
    parameter int unsigned RESOLUTION_WIDTH  = 640,
    parameter int unsigned RESOLUTION_HEIGHT = 480,
    parameter int unsigned FRAME_SKIP        = 2
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                cam_vsync,
    input  logic                cam_href,
    input  logic [7:0]          cam_data,
    ov7670_capture_if.master    wr,
    output logic                frame_done,
    output logic                short_frame
);

    localparam int unsigned AddrW = addr_width(RESOLUTION_WIDTH, RESOLUTION_HEIGHT);
    localparam int unsigned ColW  = $clog2(RESOLUTION_WIDTH + 1);
    localparam int unsigned LineW = $clog2(RESOLUTION_HEIGHT + 1);
    localparam int unsigned SkipW = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;

    localparam logic [ColW-1:0]  ColMax   = ColW'(RESOLUTION_WIDTH);
    localparam logic [LineW-1:0] LineMax  = LineW'(RESOLUTION_HEIGHT);
    localparam logic [SkipW-1:0] SkipMax  = SkipW'(FRAME_SKIP);
    localparam logic [AddrW-1:0] AddrLast = AddrW'(RESOLUTION_WIDTH * RESOLUTION_HEIGHT - 1);

    cap_state_t       state_q, state_d;
    logic             vsync_q, href_q;
    logic [SkipW-1:0] skip_q, skip_d;
    logic [ColW-1:0]  col_q, col_d;
    logic [LineW-1:0] line_q, line_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic             pend_q, pend_d;
    logic             wen_q, wen_d;
    logic [PixW-1:0]  wdata_q, wdata_d;
    logic             fd_q, fd_d;
    logic             short_q, short_d;

    logic             vs_rise, vs_fall, href_fall, wr_now;
    logic             pix_valid;
    logic [PixW-1:0]  pix;

    rgb444_pair u_pair (
        .clk_i       (pclk),
        .rst_i       (rst),
        .href_i      (cam_href),
        .data_i      (cam_data),
        .pix_valid_o (pix_valid),
        .pix_o       (pix)
    );

    assign vs_rise   = cam_vsync & ~vsync_q;
    assign vs_fall   = ~cam_vsync & vsync_q;
    assign href_fall = ~cam_href & href_q;
    assign wr_now    = (state_q == StCapture) && pix_valid && (col_q < ColMax) && (line_q < LineMax);

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        case (state_q)
            StWaitVs:  if (cam_vsync) state_d = StSync;
            StSync:    if (vs_fall) state_d = (skip_q < SkipMax) ? StSkip : StCapture;
            StSkip: begin
                if (vs_rise) begin
                    state_d = StSync;
                    if (skip_q < SkipMax) skip_d = skip_q + 1'b1;
                end
            end
            StCapture: if (vs_rise) state_d = StSync;
            default:   state_d = StWaitVs;
        endcase
    end

    // Line edges seen during vertical blanking belong to no frame and are not counted.
    always_comb begin
        col_d  = col_q;
        line_d = line_q;
        if (vs_rise) begin
            col_d  = '0;
            line_d = '0;
        end else begin
            if (href_fall) begin
                col_d = '0;
            end else if (pix_valid && col_q < ColMax) begin
                col_d = col_q + 1'b1;
            end
            if (href_fall && !cam_vsync && line_q < LineMax) line_d = line_q + 1'b1;
        end
    end

    // w_addr shows the address of the pending write, then steps after it. A write that
    // coincides with the vsync rise keeps its address; the frame reset is deferred one edge.
    always_comb begin
        addr_d = addr_q;
        pend_d = pend_q;
        if (wr_now) begin
            if (vs_rise) pend_d = 1'b1;
        end else if (vs_rise || pend_q) begin
            addr_d = '0;
            pend_d = 1'b0;
        end else if (wen_q && addr_q != AddrLast) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_comb begin
        wen_d   = wr_now;
        wdata_d = wr_now ? pix : wdata_q;
        fd_d    = (state_q == StCapture) && vs_rise;
        short_d = short_q | (fd_d && line_q < LineMax);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= StWaitVs;
            vsync_q <= 1'b1;
            href_q  <= 1'b0;
            skip_q  <= '0;
            col_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            pend_q  <= 1'b0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            fd_q    <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= cam_vsync;
            href_q  <= cam_href;
            skip_q  <= skip_d;
            col_q   <= col_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            fd_q    <= fd_d;
            short_q <= short_d;
        end
    end

    assign wr.w_addr   = addr_q;
    assign wr.w_data   = wdata_q;
    assign wr.w_en     = wen_q;
    assign frame_done  = fd_q;
    assign short_frame = short_q;

endmodule
